reg_bank: RTL and testbench
===========================

Name: reg_bank

Overview:
- Parametrised successor to the 16-bit single register.
- Holds DEPTH words of WIDTH bits each.
- Provides one synchronous write port and two combinational read ports, with optional write-to-read bypass.
- A hardware clear sequencer sweeps all entries to CLR_VAL, automatically after reset and on request. This lets the storage map to reset-less distributed RAM.
- Serves as the CPU-side register bank (A/D plus scratch) and as a generic small memory.

Parameters:
- WIDTH, 16, data width in bits.
- DEPTH, 8, number of entries (>=2).
- AW, $clog2(DEPTH), address width (derived; never overridden).
- BYPASS, 1, 1 = a read of the address being written returns wdata in the same cycle.
- CLR_VAL, 0, value written to every entry by a sweep.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- raddr_a  in  AW  read address, port A.
- rdata_a  out  WIDTH  read data, port A (combinational).
- raddr_b  in  AW  read address, port B.
- rdata_b  out  WIDTH  read data, port B (combinational).
- clr_start  in  1  single-cycle request to start a clear sweep.
- busy  out  1  high while a sweep is in progress.

Behaviour:
- Interface (decided): one clock, clk. Reset rst_n is asynchronous, active-low.
- Storage array has no reset. Only the control flops (state, ptr) are reset.
- Reset state: state=CLEAR, ptr=0, so busy=1. rdata_a and rdata_b read CLR_VAL while busy.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_start=1 at posedge. ptr loads 0.
  - CLEAR: each posedge writes mem[ptr]=CLR_VAL and increments ptr.
  - CLEAR -> IDLE at the posedge that writes entry DEPTH-1.
- Sweep latency: exactly DEPTH cycles of busy=1.
  - Request: clr_start sampled at edge N.
  - busy is high in cycles N+1 .. N+DEPTH; falls after edge N+DEPTH.
  - After reset release: busy stays high for DEPTH edges.
- busy is decoded directly from the state flop (no combinational input path).
- Write: at posedge, mem[waddr]<=wdata when we=1, busy=0, clr_start=0 and waddr<DEPTH.
- Dropped writes:
  - writes while busy;
  - writes with waddr>=DEPTH (non-power-of-2 DEPTH);
  - writes in the same cycle as clr_start (clear wins).
- Read, each port independently, combinational:
  - busy=1 -> CLR_VAL;
  - raddr>=DEPTH -> 0;
  - BYPASS=1 and an accepted write to the same address this cycle -> wdata;
  - otherwise mem[raddr].
- Both ports may read the same address at once; they return identical data.
- BYPASS=0: a read returns the old value in the write cycle and the new value from the next cycle.
- clr_start while busy: ignored. The sweep is not restarted or extended.
- rst_n asserted mid-sweep: immediately state=CLEAR, ptr=0. After release, the full sweep restarts from entry 0.
- ptr width AW. ptr never exceeds DEPTH-1; no wrap beyond the terminal compare.

Decomposition:
- Shared include hack_defs.vh: FSM state encodings ST_IDLE=1'b0, ST_CLEAR=1'b1, and default WIDTH=16.
- Sub-module reg_bank_clr_ctrl:
  - contents: FSM, ptr counter, terminal compare;
  - inputs: clk, rst_n, clr_start;
  - outputs: busy, clr_we, clr_addr.
- Top level holds the storage array, the write mux (sweep vs user port) and the read/bypass muxes.

Test Plan:
- Reset release, DEPTH=8, user writes held active:
  - busy=1 for exactly 8 cycles;
  - rdata_a/b=0 throughout;
  - afterwards all 8 entries read 0;
  - all writes attempted during busy are absent.
- Write path, BYPASS=1:
  - idle, write waddr=3, wdata=16'hBEEF, raddr_a=3 in the same cycle -> rdata_a=16'hBEEF that cycle;
  - next cycle, raddr_b=3 -> rdata_b=16'hBEEF.
- Write path, BYPASS=0:
  - same stimulus as above, with entry 3 previously 16'h1234;
  - rdata_a=16'h1234 in the write cycle, 16'hBEEF in the following cycle.
- Clear request:
  - fill entries 0..7 with 16'h0011*i, then pulse clr_start;
  - busy high for cycles N+1..N+8;
  - a second clr_start at N+3 does not extend busy;
  - afterwards all entries read CLR_VAL.
- Simultaneous events:
  - clr_start and we (waddr=5, wdata=16'hAAAA) in the same idle cycle -> entry 5 reads CLR_VAL after the sweep;
  - rst_n pulsed low at sweep cycle 4 -> busy stays high 8 full cycles after release.
- DEPTH=6 build:
  - write waddr=7 is ignored;
  - raddr_a=7 returns 0;
  - the sweep takes 6 cycles.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared constants and state encodings for reg_bank
package reg_bank_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/reg_bank_clr_ctrl.sv
// rtl/reg_bank_clr_ctrl.sv - clear sweep sequencer: FSM, entry pointer, terminal compare
module reg_bank_clr_ctrl
    import reg_bank_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_start,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [0:0]    state;
    logic [AW-1:0] ptr;

    // Reset lands in CLEAR so the reset-less storage is swept before first use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_start) begin
                        state <= ST_CLEAR;
                        ptr   <= '0;
                    end
                end
                default: begin
                    if (ptr == LAST) begin
                        state <= ST_IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy     = (state == ST_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = ptr;

endmodule

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - DEPTH x WIDTH register bank, one write port, two read ports, clear sweep
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int                 WIDTH   = DEFAULT_WIDTH,
    parameter int                 DEPTH   = 8,
    localparam int                AW      = $clog2(DEPTH),
    parameter bit                 BYPASS  = 1'b1,
    parameter logic [WIDTH-1:0]   CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             clr_start,
    output logic             busy
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          wr_in_range;
    logic          a_in_range;
    logic          b_in_range;
    logic          wr_ok;

    reg_bank_clr_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_start (clr_start),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    // Range checks only exist when DEPTH leaves unused address codes.
    if (DEPTH == (1 << AW)) begin : g_pow2
        assign wr_in_range = 1'b1;
        assign a_in_range  = 1'b1;
        assign b_in_range  = 1'b1;
    end else begin : g_npow2
        localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
        assign wr_in_range = ({1'b0, waddr}   < DEPTH_W);
        assign a_in_range  = ({1'b0, raddr_a} < DEPTH_W);
        assign b_in_range  = ({1'b0, raddr_b} < DEPTH_W);
    end

    // A clear request in the same cycle wins over the user write.
    assign wr_ok = we && !busy && !clr_start && wr_in_range;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= CLR_VAL;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = mem[raddr_a];
        if (busy) begin
            rdata_a = CLR_VAL;
        end else if (!a_in_range) begin
            rdata_a = '0;
        end else if (BYPASS && wr_ok && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
    end

    always_comb begin
        rdata_b = mem[raddr_b];
        if (busy) begin
            rdata_b = CLR_VAL;
        end else if (!b_in_range) begin
            rdata_b = '0;
        end else if (BYPASS && wr_ok && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - self-checking bench for reg_bank (bypass, no-bypass and DEPTH=6 builds)
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic        clr_start;

    logic [15:0] rda [3];
    logic [15:0] rdb [3];
    logic        bsy [3];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: stored words plus remaining busy cycles per build.
    logic [15:0] mm  [3][8];
    int          cnt [3];
    int          dep [3] = '{8, 8, 6};
    bit          byp [3] = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    reg_bank #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b1), .CLR_VAL(16'h0000)) u_byp (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rda[0]), .raddr_b(raddr_b), .rdata_b(rdb[0]),
        .clr_start(clr_start), .busy(bsy[0])
    );

    reg_bank #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b0), .CLR_VAL(16'h0000)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rda[1]), .raddr_b(raddr_b), .rdata_b(rdb[1]),
        .clr_start(clr_start), .busy(bsy[1])
    );

    reg_bank #(.WIDTH(16), .DEPTH(6), .BYPASS(1'b1), .CLR_VAL(16'h0000)) u_d6 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(rda[2]), .raddr_b(raddr_b), .rdata_b(rdb[2]),
        .clr_start(clr_start), .busy(bsy[2])
    );

    task automatic check(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d observed=%h expected=%h t=%0t", tag, k, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_read(input int k, input logic [2:0] addr);
        if (cnt[k] > 0) return 16'h0000;
        if (int'(addr) >= dep[k]) return 16'h0000;
        if (byp[k] && we && !clr_start && int'(waddr) < dep[k] && waddr == addr) return wdata;
        return mm[k][addr];
    endfunction

    function automatic void model_edge();
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                cnt[k] = dep[k];
                for (int i = 0; i < 8; i++) mm[k][i] = 16'h0000;
            end else if (cnt[k] > 0) begin
                cnt[k]--;
            end else if (clr_start) begin
                cnt[k] = dep[k];
                for (int i = 0; i < 8; i++) mm[k][i] = 16'h0000;
            end else if (we && int'(waddr) < dep[k]) begin
                mm[k][waddr] = wdata;
            end
        end
    endfunction

    // Inputs are already applied; check combinational outputs, then clock the model.
    task automatic cycle();
        #2;
        for (int k = 0; k < 3; k++) begin
            check("busy",    k, {15'b0, bsy[k]}, {15'b0, (cnt[k] > 0)});
            check("rdata_a", k, rda[k], exp_read(k, raddr_a));
            check("rdata_b", k, rdb[k], exp_read(k, raddr_b));
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; clr_start = 1'b0;
    endtask

    task automatic read_all();
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i);
            raddr_b = 3'(7 - i);
            cycle();
        end
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cnt[k] = dep[k];
            for (int i = 0; i < 8; i++) mm[k][i] = 16'h0000;
        end
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b1; waddr = 3'd0; wdata = 16'h5555;
        raddr_a = 3'd0; raddr_b = 3'd1; clr_start = 1'b0;
        @(posedge clk);
        #1;
        assert_reset();
        cycle();
        cycle();

        // Reset release with user writes held active throughout the sweep.
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            we = 1'b1;
            waddr = 3'($urandom_range(0, 7));
            wdata = 16'($urandom);
            raddr_a = 3'($urandom_range(0, 7));
            raddr_b = 3'($urandom_range(0, 7));
            cycle();
        end
        read_all();

        // Same-cycle bypass vs. old value, then next-cycle read.
        we = 1'b1; waddr = 3'd3; wdata = 16'h1234; raddr_a = 3'd0; raddr_b = 3'd1;
        cycle();
        wdata = 16'hBEEF; raddr_a = 3'd3;
        cycle();
        idle_inputs(); raddr_a = 3'd3; raddr_b = 3'd3;
        cycle();

        // Fill, clear, and a second clr_start during the sweep.
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; waddr = 3'(i); wdata = 16'(16'h0011 * i);
            cycle();
        end
        read_all();
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        cycle();
        cycle();
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        read_all();

        // clr_start and a write in the same idle cycle: clear wins.
        we = 1'b1; waddr = 3'd5; wdata = 16'h7777;
        cycle();
        wdata = 16'hAAAA; clr_start = 1'b1; raddr_a = 3'd5;
        cycle();
        idle_inputs();
        for (int i = 0; i < 9; i++) cycle();
        read_all();

        // Reset asserted at sweep cycle 4 restarts the full sweep.
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        assert_reset();
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cycle();

        // Out-of-range write/read for the DEPTH=6 build.
        we = 1'b1; waddr = 3'd7; wdata = 16'hDEAD; raddr_a = 3'd7; raddr_b = 3'd6;
        cycle();
        waddr = 3'd6; wdata = 16'hFACE;
        cycle();
        read_all();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            we        = 1'($urandom_range(0, 1));
            waddr     = 3'($urandom_range(0, 7));
            wdata     = 16'($urandom);
            raddr_a   = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
            raddr_b   = ($urandom_range(0, 3) == 0) ? raddr_a : 3'($urandom_range(0, 7));
            clr_start = ($urandom_range(0, 24) == 0);
            cycle();
        end
        read_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
